// File: rtl/mem_arbiter_if.sv
// Bundles the IFU, LSU and memory-side handshake signals of the memory arbiter.
// master = arbiter side, slave = requesters plus memory model side.
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [AW-1:0]     ifu_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_err;
  logic [DW-1:0]     ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [AW-1:0]     lsu_addr;
  logic [DW-1:0]     lsu_wdata;
  logic [DW/8-1:0]   lsu_wmask;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_err;
  logic [DW-1:0]     lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wmask;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : round-robin IFU/LSU arbiter for one shared memory port,
//               with bounded response wait and timeout error.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            last_lsu;
  logic            owner_lsu;
  logic            lat_wen;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [MW-1:0]   lat_wmask;
  logic [CW-1:0]   cnt;
  logic            err_q;
  logic [DW-1:0]   ifu_rdata_q;
  logic [DW-1:0]   lsu_rdata_q;

  logic            grant_lsu;
  logic            ifu_ready;
  logic            lsu_ready;
  logic            issue_done;
  logic            rsp_hit;
  logic            to_fire;
  logic            timeout_hit;
  logic            in_resp;

  // On a conflict the requester that did not win last time is chosen.
  assign grant_lsu   = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ifu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    issue_done = 1'b0;
    rsp_hit    = 1'b0;
    to_fire    = 1'b0;
    case (state)
      IDLE: begin
        // Ready is combinational here, so it is also masked while reset is held.
        if (rst) begin
          lsu_ready = grant_lsu;
          ifu_ready = bus.ifu_req_valid && !grant_lsu;
          if (lsu_ready || ifu_ready) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          issue_done = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          rsp_hit   = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          to_fire   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lsu    <= 1'b0;
      owner_lsu   <= 1'b0;
      lat_wen     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wmask   <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (lsu_ready) begin
        owner_lsu <= 1'b1;
        last_lsu  <= 1'b1;
        lat_wen   <= bus.lsu_wen;
        lat_addr  <= bus.lsu_addr;
        lat_wdata <= bus.lsu_wdata;
        lat_wmask <= bus.lsu_wmask;
      end else if (ifu_ready) begin
        owner_lsu <= 1'b0;
        last_lsu  <= 1'b0;
        lat_wen   <= 1'b0;
        lat_addr  <= bus.ifu_addr;
        lat_wdata <= '0;
        lat_wmask <= '0;
      end

      if (issue_done) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
      end

      // A response arriving in the timeout cycle takes priority over the error.
      if (rsp_hit || to_fire) begin
        err_q <= to_fire;
        if (owner_lsu) begin
          lsu_rdata_q <= rsp_hit ? bus.mem_rdata : '0;
        end else begin
          ifu_rdata_q <= rsp_hit ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign in_resp = (state == RESP);

  assign bus.ifu_req_ready = ifu_ready;
  assign bus.lsu_req_ready = lsu_ready;

  assign bus.ifu_rsp_valid = in_resp && !owner_lsu;
  assign bus.ifu_rsp_err   = in_resp && !owner_lsu && err_q;
  assign bus.ifu_rdata     = ifu_rdata_q;

  assign bus.lsu_rsp_valid = in_resp && owner_lsu;
  assign bus.lsu_rsp_err   = in_resp && owner_lsu && err_q;
  assign bus.lsu_rdata     = lsu_rdata_q;

  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_wen       = lat_wen;
  assign bus.mem_addr      = lat_addr;
  assign bus.mem_wdata     = lat_wdata;
  assign bus.mem_wmask     = lat_wmask;

endmodule

`default_nettype wire
